// File: rtl/hist_cdf_pkg.sv
// Shared types and width helpers for the histogram / CDF threshold engine.
package hist_cdf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        DONE
    } histState_t;

    localparam int unsigned DefaultNumBins = 256;
    localparam int unsigned DefaultCountW  = 14;

    function automatic int unsigned binIdxWidth(input int unsigned numBins);
        return $clog2(numBins);
    endfunction

    function automatic int unsigned totalWidth(input int unsigned countW, input int unsigned numBins);
        return countW + $clog2(numBins);
    endfunction

endpackage

// File: rtl/histogram_cdf_threshold_bin.sv
// Single saturating histogram bin: increment, local clear, and a flag for a hit at max.
module sat_bin_counter
    import hist_cdf_pkg::*;
#(
    parameter int unsigned COUNT_W = DefaultCountW
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               satHit
);

    always_ff @(posedge clk) begin
        if (clear || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign satHit = inc && (count == '1);

endmodule

// File: rtl/histogram_cdf_threshold.sv
// Histogram accumulation plus sequential CDF scan reporting the first bin reaching cdf_target.
// Optional macro HIST_CDF_STREAM_EN adds the registered per-bin CDF stream outputs.
module histogram_cdf_threshold
    import hist_cdf_pkg::*;
#(
    parameter int unsigned NUM_BINS  = DefaultNumBins,
    parameter int unsigned BIN_IDX_W = binIdxWidth(NUM_BINS),
    parameter int unsigned COUNT_W   = DefaultCountW,
    parameter int unsigned TOTAL_W   = totalWidth(COUNT_W, NUM_BINS)
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 pix_valid,
    input  logic [BIN_IDX_W-1:0] pix_data,
    output logic                 pix_ready,
    input  logic [TOTAL_W-1:0]   cdf_target,
    output logic                 busy,
    output logic                 thr_valid,
    output logic [BIN_IDX_W-1:0] thr_value,
    output logic                 thr_found,
`ifdef HIST_CDF_STREAM_EN
    output logic                 cdf_valid,
    output logic [BIN_IDX_W-1:0] cdf_idx,
    output logic [TOTAL_W-1:0]   cdf_value,
`endif
    output logic                 bin_sat
);

    histState_t state, nextState;

    logic [BIN_IDX_W-1:0] scanIdx;
    logic [BIN_IDX_W-1:0] matchIdx;
    logic [TOTAL_W-1:0]   acc;
    logic [TOTAL_W-1:0]   accNext;
    logic [TOTAL_W-1:0]   targetQ;
    logic                 matchFlag;
    logic                 hitNow;
    logic                 lastBin;
    logic                 startFrame;
    logic [COUNT_W-1:0]   binCount [NUM_BINS];
    logic [NUM_BINS-1:0]  binSatHit;

    assign startFrame = frame_start && ((state == IDLE) || (state == ACCUM));
    assign lastBin    = (scanIdx == BIN_IDX_W'(NUM_BINS - 1));
    assign accNext    = acc + TOTAL_W'(binCount[scanIdx]);
    assign hitNow     = !matchFlag && (accNext >= targetQ);

    generate
        for (genvar g = 0; g < NUM_BINS; g++) begin : genBins
            sat_bin_counter #(
                .COUNT_W(COUNT_W)
            ) binCounter (
                .clk    (clk),
                .clear  (clear),
                .inc    ((state == ACCUM) && pix_valid && !frame_start && (pix_data == BIN_IDX_W'(g))),
                .clr    (startFrame || ((state == SCAN) && (scanIdx == BIN_IDX_W'(g)))),
                .count  (binCount[g]),
                .satHit (binSatHit[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        thr_valid = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) nextState = ACCUM;
            end
            ACCUM: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (!frame_start && frame_end) nextState = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (lastBin) nextState = DONE;
            end
            DONE: begin
                thr_valid = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            acc       <= '0;
            scanIdx   <= '0;
            targetQ   <= '0;
            matchFlag <= 1'b0;
            matchIdx  <= '0;
            thr_value <= '0;
            thr_found <= 1'b0;
            bin_sat   <= 1'b0;
        end else begin
            if (startFrame) begin
                targetQ   <= cdf_target;
                bin_sat   <= 1'b0;
                acc       <= '0;
                scanIdx   <= '0;
                matchFlag <= 1'b0;
                matchIdx  <= '0;
            end else if ((state == ACCUM) && (|binSatHit)) begin
                bin_sat <= 1'b1;
            end
            if (state == SCAN) begin
                acc     <= accNext;
                scanIdx <= scanIdx + 1'b1;
                if (hitNow) begin
                    matchFlag <= 1'b1;
                    matchIdx  <= scanIdx;
                end
                // Outputs update only on entry to DONE; a hit on the last bin and a miss both report the last index.
                if (lastBin) begin
                    thr_found <= matchFlag || hitNow;
                    thr_value <= matchFlag ? matchIdx : scanIdx;
                end
            end
        end
    end

`ifdef HIST_CDF_STREAM_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            cdf_valid <= 1'b0;
            cdf_idx   <= '0;
            cdf_value <= '0;
        end else begin
            cdf_valid <= (state == SCAN);
            if (state == SCAN) begin
                cdf_idx   <= scanIdx;
                cdf_value <= accNext;
            end
        end
    end
`endif

endmodule

// File: tb/tb_histogram_cdf_threshold.sv
// Directed scoreboard bench: a 256x14 instance for most frames, a 256x4 instance for saturation.
`timescale 1ns/1ps
module tb_histogram_cdf_threshold;

    localparam int unsigned NB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;
    logic        frameStart;
    logic        frameEnd;
    logic        pixValid;
    logic [7:0]  pixData;
    logic [21:0] cdfTarget;
    logic        useSat;

    logic       mReady, mBusy, mThrValid, mFound, mSat;
    logic [7:0] mValue;
    logic       sReady, sBusy, sThrValid, sFound, sSat;
    logic [7:0] sValue;
`ifdef HIST_CDF_STREAM_EN
    logic        mCdfValid, sCdfValid;
    logic [7:0]  mCdfIdx, sCdfIdx;
    logic [21:0] mCdfValue;
    logic [11:0] sCdfValue;
`endif

    histogram_cdf_threshold dut (
        .clk         (clk),
        .clear       (clear),
        .frame_start (frameStart && !useSat),
        .frame_end   (frameEnd && !useSat),
        .pix_valid   (pixValid),
        .pix_data    (pixData),
        .pix_ready   (mReady),
        .cdf_target  (cdfTarget),
        .busy        (mBusy),
        .thr_valid   (mThrValid),
        .thr_value   (mValue),
        .thr_found   (mFound),
`ifdef HIST_CDF_STREAM_EN
        .cdf_valid   (mCdfValid),
        .cdf_idx     (mCdfIdx),
        .cdf_value   (mCdfValue),
`endif
        .bin_sat     (mSat)
    );

    histogram_cdf_threshold #(
        .COUNT_W(4)
    ) dutSat (
        .clk         (clk),
        .clear       (clear),
        .frame_start (frameStart && useSat),
        .frame_end   (frameEnd && useSat),
        .pix_valid   (pixValid),
        .pix_data    (pixData),
        .pix_ready   (sReady),
        .cdf_target  (cdfTarget[11:0]),
        .busy        (sBusy),
        .thr_valid   (sThrValid),
        .thr_value   (sValue),
        .thr_found   (sFound),
`ifdef HIST_CDF_STREAM_EN
        .cdf_valid   (sCdfValid),
        .cdf_idx     (sCdfIdx),
        .cdf_value   (sCdfValue),
`endif
        .bin_sat     (sSat)
    );

    logic       thrValid, thrFound, binSat, busy, pixReady;
    logic [7:0] thrValue;
    assign thrValid = useSat ? sThrValid : mThrValid;
    assign thrFound = useSat ? sFound    : mFound;
    assign thrValue = useSat ? sValue    : mValue;
    assign binSat   = useSat ? sSat      : mSat;
    assign busy     = useSat ? sBusy     : mBusy;
    assign pixReady = useSat ? sReady    : mReady;

    typedef struct packed {
        logic [7:0] value;
        logic       found;
        logic       sat;
    } exp_t;

    exp_t        expQ[$];
    int unsigned modelHist [NB];
    int unsigned modelCap;
    int unsigned modelTarget;
    logic        modelSat;
    int          checks   = 0;
    int          failures = 0;

`ifdef HIST_CDF_STREAM_EN
    int   streamPulses = 0;
    int   streamBad    = 0;
    logic lastCdfValid;
    logic [7:0] lastCdfIdx;
    always @(negedge clk) begin
        if (!useSat && mCdfValid) begin
            streamPulses++;
            if (mCdfValue != (22'(mCdfIdx) + 22'd1)) streamBad++;
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic fs, input logic fe, input logic pv, input logic [7:0] pd);
        @(negedge clk);
        frameStart = fs;
        frameEnd   = fe;
        pixValid   = pv;
        pixData    = pd;
    endtask

    task automatic modelReset(input int unsigned target);
        for (int i = 0; i < NB; i++) modelHist[i] = 0;
        modelSat    = 1'b0;
        modelTarget = target;
        modelCap    = useSat ? 15 : 16383;
        cdfTarget   = 22'(target);
    endtask

    task automatic addPixel(input logic [7:0] v);
        if (modelHist[v] < modelCap) modelHist[v]++;
        else modelSat = 1'b1;
    endtask

    task automatic startFrame(input int unsigned target);
        modelReset(target);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic pixel(input logic [7:0] v);
        drive(1'b0, 1'b0, 1'b1, v);
        addPixel(v);
    endtask

    task automatic endFrame(input logic withPix, input logic [7:0] v);
        exp_t        e;
        int unsigned cum;
        drive(1'b0, 1'b1, withPix, v);
        if (withPix) addPixel(v);
        e.value = 8'(NB - 1);
        e.found = 1'b0;
        e.sat   = modelSat;
        cum     = 0;
        for (int i = 0; i < NB; i++) begin
            cum += modelHist[i];
            if (!e.found && cum >= modelTarget) begin
                e.found = 1'b1;
                e.value = 8'(i);
            end
        end
        expQ.push_back(e);
    endtask

    task automatic waitResult(input string tag, input bit junkPix);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 600) begin
            if (junkPix) drive(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
            else drive(1'b0, 1'b0, 1'b0, 8'd0);
            lat++;
            if (lat == 1) begin
                check({tag, "_scan_busy"}, 32'(busy), 32'd1);
                check({tag, "_scan_ready"}, 32'(pixReady), 32'd0);
            end
            if (thrValid) seen = 1;
        end
`ifdef HIST_CDF_STREAM_EN
        lastCdfValid = mCdfValid;
        lastCdfIdx   = mCdfIdx;
`endif
        check({tag, "_latency"}, 32'(lat), 32'd257);
        check({tag, "_queue"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, "_value"}, 32'(thrValue), 32'(e.value));
            check({tag, "_found"}, 32'(thrFound), 32'(e.found));
            check({tag, "_sat"}, 32'(binSat), 32'(e.sat));
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check({tag, "_valid_pulse"}, 32'(thrValid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        clear      = 1'b1;
        useSat     = 1'b0;
        frameStart = 1'b0;
        frameEnd   = 1'b0;
        pixValid   = 1'b0;
        pixData    = '0;
        cdfTarget  = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check("rst_ready", 32'(mReady), 32'd0);
        check("rst_busy", 32'(mBusy), 32'd0);
        check("rst_valid", 32'(mThrValid), 32'd0);
        check("rst_value", 32'(mValue), 32'd0);
        check("rst_found", 32'(mFound), 32'd0);
        check("rst_sat", 32'(mSat), 32'd0);

        // Uniform frame
        startFrame(128);
        for (int i = 0; i < NB; i++) begin
            pixel(8'(i));
            if (i == 0) begin
                check("accum_ready", 32'(pixReady), 32'd1);
                check("accum_busy", 32'(busy), 32'd1);
            end
        end
`ifdef HIST_CDF_STREAM_EN
        streamPulses = 0;
        streamBad    = 0;
`endif
        endFrame(1'b0, 8'd0);
        waitResult("uniform", 1'b0);
`ifdef HIST_CDF_STREAM_EN
        check("stream_pulses", 32'(streamPulses), 32'd256);
        check("stream_values", 32'(streamBad), 32'd0);
        check("stream_last_valid", 32'(lastCdfValid), 32'd1);
        check("stream_last_idx", 32'(lastCdfIdx), 32'd255);
`endif

        // Skewed frame, two targets
        startFrame(120);
        repeat (100) pixel(8'd10);
        repeat (50) pixel(8'd200);
        endFrame(1'b0, 8'd0);
        waitResult("skew120", 1'b0);

        startFrame(100);
        repeat (100) pixel(8'd10);
        repeat (50) pixel(8'd200);
        endFrame(1'b0, 8'd0);
        waitResult("skew100", 1'b0);

        startFrame(0);
        pixel(8'd7);
        endFrame(1'b0, 8'd0);
        waitResult("target0", 1'b0);

        // Pixel coincident with frame_end; junk pixels during the scan
        startFrame(1);
        endFrame(1'b1, 8'd5);
        waitResult("simul", 1'b1);

        startFrame(1);
        endFrame(1'b0, 8'd0);
        waitResult("empty", 1'b0);

        // Restart mid-frame: bin 9 and the dropped pixel must not count
        startFrame(1);
        pixel(8'd9);
        modelReset(1);
        drive(1'b1, 1'b0, 1'b1, 8'd50);
        pixel(8'd60);
        endFrame(1'b0, 8'd0);
        waitResult("restart", 1'b0);

        // Reset at scan index 40
        startFrame(1);
        pixel(8'd3);
        endFrame(1'b0, 8'd0);
        repeat (40) drive(1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        check("midscan_busy", 32'(mBusy), 32'd1);
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        clear = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_back());
        check("clr_ready", 32'(mReady), 32'd0);
        check("clr_busy", 32'(mBusy), 32'd0);
        check("clr_valid", 32'(mThrValid), 32'd0);
        check("clr_value", 32'(mValue), 32'd0);
        check("clr_found", 32'(mFound), 32'd0);
        check("clr_sat", 32'(mSat), 32'd0);

        startFrame(1);
        pixel(8'd0);
        endFrame(1'b0, 8'd0);
        waitResult("fresh", 1'b0);

        // Saturation on the 4-bit counter instance
        useSat = 1'b1;
        startFrame(15);
        repeat (20) pixel(8'd3);
        endFrame(1'b0, 8'd0);
        waitResult("sat15", 1'b0);

        startFrame(16);
        repeat (20) pixel(8'd3);
        endFrame(1'b0, 8'd0);
        waitResult("sat16", 1'b0);
        useSat = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/histogram_cdf_threshold.md
Name: histogram_cdf_threshold

Overview:
- Parametrised histogram and CDF threshold engine for the binarization datapath.
- Accumulates one count per pixel value over a frame into NUM_BINS saturating bin counters.
- After the frame ends, it scans the bins sequentially, building the cumulative sum (CDF), and reports the first bin index whose CDF reaches a programmable target. That index is the binarization threshold.
- Bins are self-clearing during the scan, so the next frame can start immediately after DONE.

Parameters:
- NUM_BINS, 256, number of histogram bins; must be a power of two.
- BIN_IDX_W, $clog2(NUM_BINS), pixel value / bin index width (derived).
- COUNT_W, 14, width of each bin counter; counters saturate at 2^COUNT_W-1.
- TOTAL_W, COUNT_W+BIN_IDX_W, width of CDF accumulator and target (derived).

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- frame_start  in  1  pulse; starts accumulation and latches cdf_target.
- frame_end  in  1  pulse; ends accumulation and starts the scan.
- pix_valid  in  1  pixel qualifier.
- pix_data  in  BIN_IDX_W  pixel value; selects the bin to increment.
- pix_ready  out  1  high only in ACCUM.
- cdf_target  in  TOTAL_W  CDF level defining the threshold.
- busy  out  1  high in ACCUM or SCAN.
- thr_valid  out  1  one-cycle pulse on entry to DONE.
- thr_value  out  BIN_IDX_W  threshold bin index; held until the next thr_valid.
- thr_found  out  1  1 = target reached; 0 = target never reached (thr_value = NUM_BINS-1).
- bin_sat  out  1  sticky per frame; some bin saturated during the frame.

Behaviour:
- Reset: clear=1 on any edge forces the following, regardless of state (mid-frame or mid-scan included):
  - state=IDLE, all bins=0, accumulator=0.
  - pix_ready=0, busy=0, thr_valid=0, thr_value=0, thr_found=0, bin_sat=0.
- State IDLE:
  - frame_start moves to ACCUM, latches cdf_target into target_q and clears bin_sat.
  - frame_end and pixels are ignored.
- State ACCUM:
  - Each cycle with pix_valid=1, bin[pix_data] increments by 1 with saturation.
  - If the bin is already at max it holds, and bin_sat is set.
  - frame_end moves to SCAN next cycle. A pixel valid in the same cycle as frame_end is counted.
  - A repeated frame_start restarts the frame: bins cleared, target relatched, bin_sat cleared. A pixel in that cycle is dropped.
- State SCAN (idx from 0 to NUM_BINS-1, one bin per cycle):
  - acc_next = acc + bin[idx], zero-extended to TOTAL_W; no overflow by construction.
  - The first idx with acc_next >= target_q captures thr_value=idx and thr_found=1. Later matches are ignored.
  - bin[idx] is cleared in the same cycle it is read.
  - pix_ready=0; pixels, frame_start and frame_end are all ignored.
  - After idx=NUM_BINS-1 the engine moves to DONE.
  - Scan length is exactly NUM_BINS cycles. No early exit, so every bin gets cleared.
- State DONE:
  - Lasts one cycle: thr_valid=1, then return to IDLE.
  - If target was not reached: thr_found=0 and thr_value=NUM_BINS-1.
  - thr_valid rises NUM_BINS+1 cycles after the frame_end cycle.
- Boundary cases:
  - target_q=0: the threshold is bin 0 even if that bin is empty.
  - Empty frame with target_q>0: thr_found=0.
  - Back-to-back frames: frame_start in the DONE cycle is ignored. It must arrive in IDLE, i.e. at least 1 cycle after thr_valid.

Optional Feature:
- Macro HIST_CDF_STREAM_EN.
- Defined: adds outputs cdf_valid (1), cdf_idx (BIN_IDX_W) and cdf_value (TOTAL_W), registered.
  - During SCAN these present acc_next and idx for every bin, one cycle after the bin is read.
  - This gives NUM_BINS consecutive cdf_valid pulses; the last coincides with thr_valid.
  - All three outputs reset to 0.
- Undefined: the ports and the registers behind them do not exist. Threshold behaviour is identical.

Decomposition:
- Package hist_cdf_pkg holds:
  - the state enum (IDLE, ACCUM, SCAN, DONE);
  - default NUM_BINS/COUNT_W constants;
  - width helper functions for BIN_IDX_W and TOTAL_W.
- Sub-module sat_bin_counter: one COUNT_W counter with increment, clear and saturation flag, instantiated NUM_BINS times via generate.
- The FSM, scan index, accumulator and compare stay in the top module.

Test Plan:
- Uniform frame: NUM_BINS=256, one pixel per value 0..255, target=128 -> thr_valid at frame_end+257 cycles, thr_value=127, thr_found=1.
- Skewed frame: 100 pixels of value 10 and 50 of value 200, target=120 -> thr_value=200, thr_found=1.
  - Same frame with target=100 -> thr_value=10.
- Saturation: COUNT_W=4, 20 pixels of value 3, target=15 -> bin_sat=1, thr_value=3.
  - Same setup with target=16 -> thr_found=0, thr_value=255.
- Simultaneous events: pixel value 5 with frame_end in the same cycle, target=1 -> thr_value=5.
  - Pixels applied during SCAN are not counted.
  - The next frame, with no pixels and target=1, gives thr_found=0 (proves the bins self-cleared).
- Reset mid-scan: assert clear at scan idx 40 -> all outputs 0 next cycle.
  - A fresh frame with 1 pixel of value 0 and target=1 -> thr_value=0.
- With HIST_CDF_STREAM_EN defined: the uniform frame gives 256 cdf_valid pulses, cdf_value = idx+1, and the final pulse aligned with thr_valid.
